// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream pipeline register.
//   REG_BYPASS / REG_SIMPLE / REG_SKID : stage type selectors
//   packed_width()                      : width of the packed payload bus
//   clog2()                             : ceiling log2 for parameter arithmetic
package axis_pkg;

    localparam int REG_BYPASS = 0;
    localparam int REG_SIMPLE = 1;
    localparam int REG_SKID   = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Only enabled sideband fields take up bits in the stored vector.
    function automatic int packed_width(
        input int data_w,
        input int keep_en,
        input int keep_w,
        input int last_en,
        input int id_en,
        input int id_w,
        input int dest_en,
        input int dest_w,
        input int user_en,
        input int user_w
    );
        int w;
        w = data_w;
        if (keep_en != 0) w += keep_w;
        if (last_en != 0) w += 1;
        if (id_en != 0)   w += id_w;
        if (dest_en != 0) w += dest_w;
        if (user_en != 0) w += user_w;
        return w;
    endfunction

endpackage

// File: rtl/axis_pipeline_stage.sv
// One AXI-Stream register stage carrying an opaque payload vector.
//   clk, rst_n                  : clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready   : upstream side
//   m_tdata/m_tvalid/m_tready   : downstream side
// REG_TYPE selects bypass wires, a simple register (1 word) or a skid buffer (2 words).
module axis_pipeline_stage
    import axis_pkg::*;
#(
    parameter int REG_TYPE = REG_SKID,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    if (REG_TYPE == REG_SKID) begin : g_skid
        logic [WIDTH-1:0] out_data_q, out_data_d;
        logic [WIDTH-1:0] temp_data_q, temp_data_d;
        logic             out_valid_q, out_valid_d;
        logic             temp_valid_q, temp_valid_d;
        logic             ready_q, ready_d;

        always_comb begin
            out_valid_d  = out_valid_q;
            temp_valid_d = temp_valid_q;
            out_data_d   = out_data_q;
            temp_data_d  = temp_data_q;
            // Registered ready looks one word ahead: stay open unless the word that may
            // arrive this edge would have nowhere to go on the next one.
            ready_d = m_tready || (!temp_valid_q && (!out_valid_q || !s_tvalid));

            if (ready_q) begin
                // Temp is always empty while ready_q is high.
                if (m_tready || !out_valid_q) begin
                    out_valid_d = s_tvalid;
                    out_data_d  = s_tdata;
                end else begin
                    temp_valid_d = s_tvalid;
                    temp_data_d  = s_tdata;
                end
            end else if (m_tready) begin
                out_valid_d  = temp_valid_q;
                out_data_d   = temp_data_q;
                temp_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_valid_q  <= 1'b0;
                temp_valid_q <= 1'b0;
                ready_q      <= 1'b0;
            end else begin
                out_valid_q  <= out_valid_d;
                temp_valid_q <= temp_valid_d;
                ready_q      <= ready_d;
            end
        end

        // Payload registers carry no reset.
        always_ff @(posedge clk) begin
            out_data_q  <= out_data_d;
            temp_data_q <= temp_data_d;
        end

        assign s_tready = ready_q;
        assign m_tvalid = out_valid_q;
        assign m_tdata  = out_data_q;

    end else if (REG_TYPE == REG_SIMPLE) begin : g_simple
        logic [WIDTH-1:0] out_data_q;
        logic             out_valid_q;
        logic             active_q;

        // active_q keeps ready low through reset and for the first edge after it.
        assign s_tready = active_q && (m_tready || !out_valid_q);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                active_q    <= 1'b0;
            end else begin
                active_q <= 1'b1;
                if (s_tready) begin
                    out_valid_q <= s_tvalid;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (s_tready && s_tvalid) begin
                out_data_q <= s_tdata;
            end
        end

        assign m_tvalid = out_valid_q;
        assign m_tdata  = out_data_q;

    end else begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign s_tready = m_tready;
        assign m_tvalid = s_tvalid;
        assign m_tdata  = s_tdata;
    end

endmodule

// File: rtl/axis_pipeline_register.sv
// Chain of LENGTH AXI-Stream register stages with live occupancy reporting.
//   clk, rst_n     : clock, synchronous active-low reset
//   s_axis_t*      : input stream (tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser)
//   m_axis_t*      : output stream (same fields)
//   occupancy      : words currently held across all stages
//   empty          : occupancy == 0
// Enabled sideband fields are packed with tdata into one vector per stage; disabled
// fields are driven to constants on the output.
module axis_pipeline_register
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int REG_TYPE    = REG_SKID,
    parameter int LENGTH      = 2,
    parameter int CNT_WIDTH   = clog2(2 * LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  empty
);

    localparam int KEEP_W    = (KEEP_ENABLE != 0) ? KEEP_WIDTH : 0;
    localparam int LAST_W    = (LAST_ENABLE != 0) ? 1 : 0;
    localparam int ID_W      = (ID_ENABLE != 0) ? ID_WIDTH : 0;
    localparam int DEST_W    = (DEST_ENABLE != 0) ? DEST_WIDTH : 0;
    localparam int KEEP_OFF  = DATA_WIDTH;
    localparam int LAST_OFF  = KEEP_OFF + KEEP_W;
    localparam int ID_OFF    = LAST_OFF + LAST_W;
    localparam int DEST_OFF  = ID_OFF + ID_W;
    localparam int USER_OFF  = DEST_OFF + DEST_W;
    localparam int BUS_WIDTH = packed_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, LAST_ENABLE,
                                            ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH,
                                            USER_ENABLE, USER_WIDTH);

    logic [BUS_WIDTH-1:0] s_bus;
    logic [BUS_WIDTH-1:0] m_bus;

    // Field packing / unpacking
    assign s_bus[DATA_WIDTH-1:0] = s_axis_tdata;
    assign m_axis_tdata          = m_bus[DATA_WIDTH-1:0];

    if (KEEP_ENABLE != 0) begin : g_keep
        assign s_bus[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep                  = m_bus[KEEP_OFF +: KEEP_WIDTH];
    end else begin : g_no_keep
        logic unused_keep;
        assign unused_keep  = ^s_axis_tkeep;
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign s_bus[LAST_OFF] = s_axis_tlast;
        assign m_axis_tlast    = m_bus[LAST_OFF];
    end else begin : g_no_last
        logic unused_last;
        assign unused_last  = s_axis_tlast;
        assign m_axis_tlast = 1'b1;
    end

    if (ID_ENABLE != 0) begin : g_id
        assign s_bus[ID_OFF +: ID_WIDTH] = s_axis_tid;
        assign m_axis_tid                = m_bus[ID_OFF +: ID_WIDTH];
    end else begin : g_no_id
        logic unused_id;
        assign unused_id  = ^s_axis_tid;
        assign m_axis_tid = '0;
    end

    if (DEST_ENABLE != 0) begin : g_dest
        assign s_bus[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
        assign m_axis_tdest                  = m_bus[DEST_OFF +: DEST_WIDTH];
    end else begin : g_no_dest
        logic unused_dest;
        assign unused_dest  = ^s_axis_tdest;
        assign m_axis_tdest = '0;
    end

    if (USER_ENABLE != 0) begin : g_user
        assign s_bus[USER_OFF +: USER_WIDTH] = s_axis_tuser;
        assign m_axis_tuser                  = m_bus[USER_OFF +: USER_WIDTH];
    end else begin : g_no_user
        logic unused_user;
        assign unused_user  = ^s_axis_tuser;
        assign m_axis_tuser = '0;
    end

    // Stage chain; per-stage link signals keep the combinational ready path of
    // simple stages free of self-referencing vectors.
    for (genvar i = 0; i < LENGTH; i++) begin : g_stage
        logic [BUS_WIDTH-1:0] in_data;
        logic                 in_valid;
        logic                 in_ready;
        logic [BUS_WIDTH-1:0] out_data;
        logic                 out_valid;
        logic                 out_ready;

        if (i == 0) begin : g_head
            assign in_data  = s_bus;
            assign in_valid = s_axis_tvalid;
        end else begin : g_link
            assign in_data  = g_stage[i-1].out_data;
            assign in_valid = g_stage[i-1].out_valid;
        end

        if (i == LENGTH - 1) begin : g_tail
            assign out_ready = m_axis_tready;
        end else begin : g_next
            assign out_ready = g_stage[i+1].in_ready;
        end

        axis_pipeline_stage #(
            .REG_TYPE (REG_TYPE),
            .WIDTH    (BUS_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .s_tdata  (in_data),
            .s_tvalid (in_valid),
            .s_tready (in_ready),
            .m_tdata  (out_data),
            .m_tvalid (out_valid),
            .m_tready (out_ready)
        );
    end

    assign s_axis_tready = g_stage[0].in_ready;
    assign m_axis_tvalid = g_stage[LENGTH-1].out_valid;
    assign m_bus         = g_stage[LENGTH-1].out_data;

    // Occupancy from the end-point handshakes only.
    if (REG_TYPE == REG_BYPASS) begin : g_no_occ
        assign occupancy = '0;
    end else begin : g_occ
        logic                 s_fire;
        logic                 m_fire;
        logic [CNT_WIDTH-1:0] occ_q, occ_d;

        assign s_fire = s_axis_tvalid && s_axis_tready;
        assign m_fire = m_axis_tvalid && m_axis_tready;

        always_comb begin
            occ_d = occ_q;
            if (s_fire && !m_fire) begin
                occ_d = occ_q + CNT_WIDTH'(1);
            end else if (!s_fire && m_fire) begin
                occ_d = occ_q - CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
    end

    assign empty = (occupancy == '0);

endmodule

// File: tb/tb_axis_pipeline_register.sv
// Self-checking bench: skid pipe (LENGTH 2) against a queue scoreboard, plus simple
// and bypass pipes (LENGTH 3) for latency and capacity.
module tb_axis_pipeline_register;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared source / sink controls
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic [0:0] s_tuser = '0;
    logic [0:0] s_tkeep = 1'b1;
    logic [7:0] s_tid = '0;
    logic [7:0] s_tdest = '0;
    logic       m_tready = 1'b0;

    // Skid DUT outputs (k_), simple (p_), bypass (b_)
    logic       k_s_tready, k_m_tvalid, k_m_tlast, k_empty;
    logic [7:0] k_m_tdata, k_m_tid, k_m_tdest;
    logic [0:0] k_m_tkeep, k_m_tuser;
    logic [2:0] k_occ;
    logic       p_s_tready, p_m_tvalid, p_m_tlast, p_empty;
    logic [7:0] p_m_tdata, p_m_tid, p_m_tdest;
    logic [0:0] p_m_tkeep, p_m_tuser;
    logic [2:0] p_occ;
    logic       b_s_tready, b_m_tvalid, b_m_tlast, b_empty;
    logic [7:0] b_m_tdata, b_m_tid, b_m_tdest;
    logic [0:0] b_m_tkeep, b_m_tuser;
    logic [2:0] b_occ;

    axis_pipeline_register #(.REG_TYPE(2), .LENGTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(k_s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(k_m_tdata), .m_axis_tkeep(k_m_tkeep), .m_axis_tvalid(k_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(k_m_tlast), .m_axis_tid(k_m_tid),
        .m_axis_tdest(k_m_tdest), .m_axis_tuser(k_m_tuser),
        .occupancy(k_occ), .empty(k_empty)
    );

    axis_pipeline_register #(.REG_TYPE(1), .LENGTH(3)) dut_simple (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(p_s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(p_m_tdata), .m_axis_tkeep(p_m_tkeep), .m_axis_tvalid(p_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(p_m_tlast), .m_axis_tid(p_m_tid),
        .m_axis_tdest(p_m_tdest), .m_axis_tuser(p_m_tuser),
        .occupancy(p_occ), .empty(p_empty)
    );

    axis_pipeline_register #(.REG_TYPE(0), .LENGTH(3)) dut_bypass (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
        .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
        .occupancy(b_occ), .empty(b_empty)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    beat_t mon_p[$];
    beat_t mon_b[$];
    int    accepted = 0;
    int    emitted = 0;
    int    cyc = 0;
    int    occ_max = 0;
    int    p_acc = 0;
    int    b_acc = 0;
    int    lat_exp = 2;
    bit    lat_chk = 1'b0;
    bit    mon_en = 1'b0;
    bit    hold_prev = 1'b0;
    logic [9:0] hold_val = '0;
    bit    k_sfire = 1'b0;
    bit    k_mfire = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: observe at the falling edge, update the model, return after the
    // rising edge with inputs free to change.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        check_eq("occupancy", 32'(k_occ), 32'(accepted - emitted));
        check_eq("empty", 32'(k_empty), 32'(accepted == emitted));
        if (int'(k_occ) > occ_max) occ_max = int'(k_occ);
        if (hold_prev) begin
            check_eq("hold_valid", 32'(k_m_tvalid), 32'd1);
            check_eq("hold_payload", 32'({k_m_tuser, k_m_tlast, k_m_tdata}), 32'(hold_val));
        end
        k_sfire = s_tvalid && k_s_tready && rst_n;
        k_mfire = k_m_tvalid && m_tready && rst_n;
        if (!rst_n) begin
            exp_q.delete();
            accepted = 0;
            emitted = 0;
            hold_prev = 1'b0;
        end else begin
            if (k_mfire) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", 32'(k_m_tvalid), 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    emitted++;
                    check_eq("out_data", 32'(k_m_tdata), 32'(b.data));
                    check_eq("out_last", 32'(k_m_tlast), 32'(b.last));
                    check_eq("out_user", 32'(k_m_tuser), 32'(b.user));
                    if (lat_chk) check_eq("latency", 32'(cyc - b.cyc), 32'(lat_exp));
                end
            end
            if (k_sfire) begin
                exp_q.push_back('{data: s_tdata, last: s_tlast, user: s_tuser[0], cyc: cyc});
                accepted++;
            end
            hold_prev = k_m_tvalid && !m_tready;
            hold_val = {k_m_tuser, k_m_tlast, k_m_tdata};
            if (s_tvalid && p_s_tready) p_acc++;
            if (s_tvalid && b_s_tready) b_acc++;
            if (mon_en && p_m_tvalid && m_tready)
                mon_p.push_back('{data: p_m_tdata, last: p_m_tlast, user: p_m_tuser[0], cyc: cyc});
            if (mon_en && b_m_tvalid && m_tready)
                mon_b.push_back('{data: b_m_tdata, last: b_m_tlast, user: b_m_tuser[0], cyc: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input int n, input string tag);
        int target;
        target = accepted + n;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast = 1'b0;
        for (int i = 0; i < 32 && accepted < target; i++) begin
            tick();
            if (k_sfire) s_tdata = s_tdata + 8'd1;
        end
        s_tvalid = 1'b0;
        check_eq(tag, 32'(accepted), 32'(target));
    endtask

    task automatic drain(input string tag);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 40 && accepted != emitted; i++) tick();
        check_eq(tag, 32'(k_empty), 32'd1);
    endtask

    initial begin
        int c0, acc0, em0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", 32'(k_m_tvalid), 32'd0);
        check_eq("rst_s_tready", 32'(k_s_tready), 32'd0);
        check_eq("rst_empty", 32'(k_empty), 32'd1);
        check_eq("rst_occ", 32'(k_occ), 32'd0);
        check_eq("rst_tkeep_const", 32'(k_m_tkeep), 32'd1);
        check_eq("rst_tid_const", 32'(k_m_tid), 32'd0);
        check_eq("rst_tdest_const", 32'(k_m_tdest), 32'd0);
        check_eq("rst_simple_tready", 32'(p_s_tready), 32'd0);
        check_eq("rst_simple_tvalid", 32'(p_m_tvalid), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 32'(k_s_tready), 32'd0);
        tick();
        check_eq("first_ready", 32'(k_s_tready), 32'd1);
        tick();

        // Smoke on all three pipes, m_tready held high
        m_tready = 1'b1;
        lat_chk = 1'b1;
        mon_en = 1'b1;
        occ_max = 0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata = 8'(i + 1);
            s_tlast = (i == 3);
            s_tuser = 1'(i);
            tick();
            check_eq("smoke_accept", 32'(k_sfire), 32'd1);
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        repeat (6) tick();
        lat_chk = 1'b0;
        mon_en = 1'b0;
        check_eq("smoke_emitted", 32'(emitted), 32'd4);
        check_eq("smoke_occ_peak", 32'(occ_max), 32'd2);
        check_eq("simple_beats", 32'(mon_p.size()), 32'd4);
        check_eq("bypass_beats", 32'(mon_b.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < mon_p.size()) begin
                check_eq("simple_latency", 32'(mon_p[i].cyc - c0), 32'(i + 3));
                check_eq("simple_data", 32'(mon_p[i].data), 32'(i + 1));
                check_eq("simple_last", 32'(mon_p[i].last), 32'(i == 3));
            end
            if (i < mon_b.size()) begin
                check_eq("bypass_latency", 32'(mon_b[i].cyc - c0), 32'(i));
                check_eq("bypass_data", 32'(mon_b[i].data), 32'(i + 1));
                check_eq("bypass_last", 32'(mon_b[i].last), 32'(i == 3));
            end
        end

        // Backpressure: continuous valid, no ready downstream
        acc0 = accepted;
        em0 = emitted;
        p_acc = 0;
        b_acc = 0;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h10;
        repeat (10) begin
            tick();
            if (k_sfire) s_tdata = s_tdata + 8'd1;
        end
        check_eq("bp_accepted", 32'(accepted - acc0), 32'd4);
        check_eq("bp_s_tready", 32'(k_s_tready), 32'd0);
        check_eq("bp_occ", 32'(k_occ), 32'd4);
        check_eq("simple_capacity", 32'(p_acc), 32'd3);
        check_eq("simple_occ", 32'(p_occ), 32'd3);
        check_eq("bypass_capacity", 32'(b_acc), 32'd0);
        check_eq("bypass_occ", 32'(b_occ), 32'd0);
        check_eq("bypass_empty", 32'(b_empty), 32'd1);
        drain("bp_drain_empty");
        check_eq("bp_drained", 32'(emitted - em0), 32'd4);

        // Simultaneous accept and emit with two words held
        load(2, "sim_load");
        repeat (3) tick();
        check_eq("sim_occ_before", 32'(k_occ), 32'd2);
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        tick();
        check_eq("sim_both_fire", 32'({k_sfire, k_mfire}), 32'd3);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check_eq("sim_occ_after", 32'(k_occ), 32'd2);
        drain("sim_drain_empty");

        // Reset with three words of an open frame held
        load(3, "rst_load");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_m_tvalid", 32'(k_m_tvalid), 32'd0);
        check_eq("midrst_occ", 32'(k_occ), 32'd0);
        check_eq("midrst_s_tready", 32'(k_s_tready), 32'd0);
        tick();
        check_eq("midrst_ready_back", 32'(k_s_tready), 32'd1);
        m_tready = 1'b1;
        repeat (6) tick();
        check_eq("midrst_no_stale", 32'(emitted), 32'd0);

        // Random handshake, 1000 beats
        acc0 = accepted;
        em0 = emitted;
        s_tvalid = 1'b0;
        for (int i = 0; i < 20000 && (accepted - acc0) < 1000; i++) begin
            m_tready = 1'($urandom);
            if (!s_tvalid || k_sfire) begin
                s_tvalid = 1'($urandom);
                s_tdata = 8'($urandom);
                s_tlast = 1'($urandom);
                s_tuser = 1'($urandom);
            end
            tick();
        end
        s_tvalid = 1'b0;
        check_eq("rand_accepted", 32'(accepted - acc0), 32'd1000);
        drain("rand_drain_empty");
        check_eq("rand_emitted", 32'(emitted - em0), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
